// File: rtl/mul_csa_resolve_pkg.sv
// Shared types for the multiplier carry-propagate stage: XLEN default,
// RV32M multiply funct3 codes, and the S1/S2 pipeline register layouts.
package mul_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;

    typedef struct packed {
        logic [XLEN-1:0] lo;
        logic            c1;
        logic [XLEN-1:0] sum_hi;
        logic [XLEN-1:0] carry_hi;
        logic            hi_sel;
        logic [4:0]      rd;
    } mul_s1_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
    } mul_s2_t;

    // Every code other than MUL (including unused ones) selects the high word.
    function automatic logic sel_hi(input logic [2:0] funct3);
        return funct3 != MUL;
    endfunction

endpackage

// File: rtl/mul_csa_resolve_if.sv
// Handshake bundle between the compressor tree, this resolve stage and the
// execute stage. slave = the resolve block, master = producer/consumer side.
interface mul_csa_resolve_if
    import mul_pkg::*;
#(
    parameter int XLEN = mul_pkg::XLEN
);
    logic              in_valid;
    logic              in_ready;
    logic [2*XLEN-1:0] in_sum;
    logic [2*XLEN-1:0] in_carry;
    logic [2:0]        in_funct3;
    logic [4:0]        in_rd;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_result;
    logic [4:0]        out_rd;

    modport slave (
        input  in_valid, in_sum, in_carry, in_funct3, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_rd
    );

    modport master (
        output in_valid, in_sum, in_carry, in_funct3, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_rd
    );
endinterface

// File: rtl/mul_csa_resolve_cpa.sv
// XLEN-bit carry-propagate adder with carry-in and carry-out; one instance
// resolves the low word, another the high word using the low carry-out.
module cpa_xlen #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    // Widen by one bit so the carry-out falls out of the addition.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/mul_csa_resolve.sv
// Final carry-propagate stage of the Wallace multiplier: resolves sum/carry
// into a product over two pipeline stages (low word, then high word) and
// returns the RV32M-selected word over valid/ready.
// Optional macro MUL_RESOLVE_LOW_FASTPATH_EN: MUL results retire straight
// from S1 when S2 is empty and the consumer is ready (1-cycle latency).
module mul_csa_resolve
    import mul_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    mul_csa_resolve_if.slave         bus,
    output logic                     busy
);

    mul_s1_t         s1_q, s1_d;
    mul_s2_t         s2_q, s2_d;
    logic            s1_valid_q, s1_valid_d;
    logic            s2_valid_q, s2_valid_d;

    logic [XLEN-1:0] lo_sum;
    logic            lo_cout;
    logic [XLEN-1:0] hi_sum;
    logic            hi_cout_unused;

    logic            s2_free;
    logic            s1_adv;
    logic            s1_to_s2;
    logic            fast_vld;
    logic            accept;

    cpa_xlen #(.W(XLEN)) u_cpa_lo (
        .a    (bus.in_sum[XLEN-1:0]),
        .b    (bus.in_carry[XLEN-1:0]),
        .cin  (1'b0),
        .sum  (lo_sum),
        .cout (lo_cout)
    );

    // High word wraps to XLEN bits, so its carry-out is intentionally dropped.
    cpa_xlen #(.W(XLEN)) u_cpa_hi (
        .a    (s1_q.sum_hi),
        .b    (s1_q.carry_hi),
        .cin  (s1_q.c1),
        .sum  (hi_sum),
        .cout (hi_cout_unused)
    );

    // Handshake, advance decisions, next-state for both stages and outputs.
    always_comb begin
        s2_free  = !s2_valid_q || bus.out_ready;
        s1_adv   = s1_valid_q && s2_free;
`ifdef MUL_RESOLVE_LOW_FASTPATH_EN
        fast_vld = s1_valid_q && !s1_q.hi_sel && !s2_valid_q;
`else
        fast_vld = 1'b0;
`endif
        // A fast-path retirement leaves S1 without entering S2.
        s1_to_s2 = s1_adv && !(fast_vld && bus.out_ready);

        bus.in_ready = !flush && (!s1_valid_q || s1_adv);
        accept       = bus.in_valid && bus.in_ready;

        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        if (accept) begin
            s1_d.lo       = lo_sum;
            s1_d.c1       = lo_cout;
            s1_d.sum_hi   = bus.in_sum[2*XLEN-1:XLEN];
            s1_d.carry_hi = bus.in_carry[2*XLEN-1:XLEN];
            s1_d.hi_sel   = sel_hi(bus.in_funct3);
            s1_d.rd       = bus.in_rd;
            s1_valid_d    = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        s2_d       = s2_q;
        s2_valid_d = s2_valid_q;
        if (s1_to_s2) begin
            s2_d.result = s1_q.hi_sel ? hi_sum : s1_q.lo;
            s2_d.rd     = s1_q.rd;
            s2_valid_d  = 1'b1;
        end else if (bus.out_ready) begin
            s2_valid_d = 1'b0;
        end

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end

        bus.out_valid = s2_valid_q || fast_vld;
`ifdef MUL_RESOLVE_LOW_FASTPATH_EN
        bus.out_result = s2_valid_q ? s2_q.result : s1_q.lo;
        bus.out_rd     = s2_valid_q ? s2_q.rd     : s1_q.rd;
`else
        bus.out_result = s2_q.result;
        bus.out_rd     = s2_q.rd;
`endif
        busy = s1_valid_q || s2_valid_q;
    end

    // Pipeline registers; reset clears valids and the visible result/tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

endmodule

// File: doc/mul_csa_resolve.md
# mul_csa_resolve

Final carry-propagate stage of the M-extension Wallace multiplier. It consumes the redundant sum/carry pair left after the last 4:2 compressor row and resolves it into a binary product with a two-stage split-carry adder. It then selects the low or high XLEN word per the RV32M opcode and returns it to the execute stage over a valid/ready handshake. The block sustains one result per cycle and supports pipeline flush.

## Interface
- XLEN, 32, operand width; the product and the sum/carry vectors are 2*XLEN bits
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  kills every in-flight entry
- in_valid  in  1  a sum/carry pair is presented
- in_ready  out  1  the block accepts the pair this cycle
- in_sum  in  2*XLEN  sum vector from the compressor tree
- in_carry  in  2*XLEN  carry vector, already weight-aligned (bit i carries weight 2^i)
- in_funct3  in  3  RV32M funct3 (MUL/MULH/MULHSU/MULHU)
- in_rd  in  5  destination tag, passed through unchanged
- out_valid  out  1  a result is presented
- out_ready  in  1  the consumer accepts the result
- out_result  out  XLEN  selected product word
- out_rd  out  5  tag of out_result
- busy  out  1  either stage holds a valid entry

## Operation
- Product = (in_sum + in_carry) mod 2^(2*XLEN); no sign handling here, because upstream has already sign-extended the partial products.
- Stage 1 (S1), on accept:
  - registers lo = in_sum[XLEN-1:0] + in_carry[XLEN-1:0] and the carry-out c1;
  - registers the upper halves of sum and carry, hi_sel = (funct3 != MUL), and rd.
- Stage 2 (S2), on S1 advance:
  - computes hi = sum_hi + carry_hi + c1, wrapping to XLEN bits;
  - registers result = hi_sel ? hi : lo, plus rd.
- Outputs: out_valid = s2_valid; out_result and out_rd come directly from the S2 registers.
- Advance rules:
  - s2_free = !s2_valid || out_ready;
  - S1 advances when s1_valid && s2_free;
  - in_ready = !flush && (!s1_valid || s1 advances). in_ready has a combinational path from out_ready.
- Entries stay in order and are never dropped or duplicated.
- A funct3 value outside the four M-multiply codes is treated as a high-word select; upstream never issues one.

## Timing
- Reset: s1_valid = s2_valid = 0, out_valid = 0, out_result = 0, out_rd = 0, busy = 0, in_ready = 1 on the cycle after rst deasserts.
- Latency: a pair accepted in cycle t appears with out_valid in cycle t+2 when there is no stall.
- Throughput: one accept per cycle while out_ready stays high.
- Stall: while out_valid && !out_ready, out_result and out_rd hold stable. S1 holds if full; in_ready drops once both stages are full.
- Full pipeline with out_ready = 1: the output retires, S1 moves to S2 and a new input is accepted, all in the same cycle.
- Flush: on the next edge s1_valid and s2_valid clear. A result presented during the flush cycle may still complete its handshake in that cycle. A concurrent in_valid is not accepted.
- Reset mid-operation: all entries are discarded; rst overrides flush and the handshake.

## Configuration
- MUL_RESOLVE_LOW_FASTPATH_EN defined:
  - an S1 entry with hi_sel = 0 retires directly from S1 when s2_valid = 0 and out_ready = 1, with out_result = lo;
  - this gives MUL a 1-cycle latency;
  - out_valid = s2_valid || (s1_valid && !s1_hi_sel && !s2_valid);
  - if out_ready = 0, the entry moves to S2 normally;
  - ordering is preserved because the fast path fires only when S2 is empty.
- Not defined: every entry takes 2 cycles and the fast-path logic is absent.

## Structure
- The shared package mul_pkg holds:
  - the XLEN default;
  - the funct3 localparams MUL=3'b000, MULH=3'b001, MULHSU=3'b010, MULHU=3'b011;
  - the typedef struct mul_s1_t (lo, c1, sum_hi, carry_hi, hi_sel, rd);
  - the typedef struct mul_s2_t (result, rd).
- The sub-module cpa_xlen (XLEN-bit adder with carry-in and carry-out) is instantiated twice: once in S1 with cin = 0 and once in S2 with cin = c1.

## Test plan
- Cross-half carry: in_sum = 0x0000_0001_FFFF_FFFF, in_carry = 0x1. MUL -> 0x0000_0000; MULH -> 0x0000_0002. Each arrives 2 cycles after accept.
- Back-to-back traffic: 8 pairs on consecutive cycles with out_ready = 1. Results arrive in order, one per cycle, from t+2 onward, with in_ready held at 1.
- Backpressure: hold out_ready = 0 for 5 cycles with 3 inputs offered. in_ready drops after 2 accepts and out_result stays stable. Release yields the 3 results in order with no loss.
- Flush: flush with both stages full and in_valid = 1. Next cycle out_valid = 0 and busy = 0; the flush-cycle input is not accepted.
- Reset mid-operation: rst while busy. Next cycle all outputs are 0, then normal operation resumes (e.g. 0x6 + 0x1, MUL -> 0x7).
- Fast path (macro defined): an isolated MUL with sum = 0x5, carry = 0x3 gives out_valid at t+1 with 0x8. With the macro undefined the same stimulus gives t+2.
